// File: rtl/qupls_decode_src_regs.sv
// Multi-lane source-register decoder: maps each lane's instruction to architectural Ra/Rb
// through one registered stage, and carries REGX prefix extension bits across lanes and groups.
module qupls_decode_src_regs #(
    parameter int          LANES   = 4,
    parameter int          RF      = 6,
    parameter int          XW      = 1,
    parameter int          IW      = 40,
    parameter logic [6:0]  OP_REGX = 7'h7C,
    parameter logic [6:0]  OP_RTS  = 7'h29,
    parameter logic [6:0]  OP_RTD  = 7'h2A,
    parameter logic [6:0]  OP_DBRA = 7'h28,
    parameter logic [6:0]  OP_FLT2 = 7'h62,
    parameter logic [6:0]  OP_FLT3 = 7'h63,
    localparam int         AW      = RF + XW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_lane_v,
    input  logic [LANES-1:0][IW-1:0]      in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_lane_v,
    output logic [LANES-1:0]              out_is_prefix,
    output logic [LANES-1:0][AW-1:0]      out_Ra,
    output logic [LANES-1:0][AW-1:0]      out_Rb,
    output logic                          pend_regx
);

    logic [XW-1:0]             pend_xa, pend_xb;
    logic [LANES-1:0]          d_pfx;
    logic [LANES-1:0][AW-1:0]  d_ra, d_rb;
    logic                      nxt_pend;
    logic [XW-1:0]             nxt_xa, nxt_xb;
    logic                      accept;
    logic                      unused_hi;

    function automatic logic [AW-1:0] decode_ra(input logic [IW-1:0] ir, input logic [XW-1:0] x);
        logic [AW-1:0] r;
        case (ir[6:0])
            OP_RTS:           r = {x, ir[7 +: RF]};
            OP_RTD:           r = AW'(62);
            OP_DBRA:          r = AW'(55);
            OP_FLT2, OP_FLT3: r = {x, RF'(ir[16:12])};
            default:          r = {x, ir[13 +: RF]};
        endcase
        return r;
    endfunction

    function automatic logic [AW-1:0] decode_rb(input logic [IW-1:0] ir, input logic [XW-1:0] y);
        logic [AW-1:0] r;
        case (ir[6:0])
            OP_RTS, OP_RTD, OP_DBRA: r = '0;
            OP_FLT2, OP_FLT3:        r = {y, RF'(ir[21:17])};
            default:                 r = {y, ir[19 +: RF]};
        endcase
        return r;
    endfunction

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        logic          have;
        logic [XW-1:0] cx, cy;
        // NOTE: every variable gets a default before any conditional write, so none can hold its value (no latch).
        d_pfx     = '0;
        d_ra      = '0;
        d_rb      = '0;
        unused_hi = 1'b0;
        // NOTE: blocking assignments are deliberate: the live prefix ripples from lane to lane in one evaluation.
        have = pend_regx;
        cx   = pend_xa;
        cy   = pend_xb;
        for (int i = 0; i < LANES; i++) begin
            unused_hi = unused_hi ^ (^in_instr[i][IW-1:25]);
            if (in_lane_v[i]) begin
                if (in_instr[i][6:0] == OP_REGX) begin
                    // A younger prefix replaces any unconsumed older one.
                    d_pfx[i] = 1'b1;
                    have     = 1'b1;
                    cx       = in_instr[i][7 +: XW];
                    cy       = in_instr[i][7+XW +: XW];
                end else begin
                    d_ra[i] = decode_ra(in_instr[i], have ? cx : '0);
                    d_rb[i] = decode_rb(in_instr[i], have ? cy : '0);
                    have    = 1'b0;
                end
            end
        end
        nxt_pend = have;
        nxt_xa   = have ? cx : '0;
        nxt_xb   = have ? cy : '0;
    end

    // NOTE: the output data registers are reset as well, since downstream and debug observe them as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_lane_v    <= '0;
            out_is_prefix <= '0;
            out_Ra        <= '0;
            out_Rb        <= '0;
            pend_regx     <= 1'b0;
            pend_xa       <= '0;
            pend_xb       <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_lane_v <= '0;
            pend_regx  <= 1'b0;
            pend_xa    <= '0;
            pend_xb    <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_lane_v    <= in_lane_v;
            out_is_prefix <= d_pfx;
            out_Ra        <= d_ra;
            out_Rb        <= d_rb;
            pend_regx     <= nxt_pend;
            pend_xa       <= nxt_xa;
            pend_xb       <= nxt_xb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
